// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and default timing for the alarm ring controller
package alarm_pkg;

    localparam logic [2:0] DISARMED = 3'd0;
    localparam logic [2:0] ARMED    = 3'd1;
    localparam logic [2:0] RINGING  = 3'd2;
    localparam logic [2:0] SNOOZE   = 3'd3;
    localparam logic [2:0] LOCKOUT  = 3'd4;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

    typedef enum logic [2:0] {
        ST_DISARMED = DISARMED,
        ST_ARMED    = ARMED,
        ST_RINGING  = RINGING,
        ST_SNOOZE   = SNOOZE,
        ST_LOCKOUT  = LOCKOUT
    } alarm_state_t;

    // Second-counter width covering the longer of the two intervals, never zero.
    function automatic int sec_width(input int ring_secs, input int snooze_secs);
        int longest;
        longest = (ring_secs > snooze_secs) ? ring_secs : snooze_secs;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// rtl/alarm_sec_timer.sv - shared 1 Hz second counter with per-state terminal count
module alarm_sec_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         done
);

    logic [W-1:0] sec_cnt;

    // Wraps to zero on the terminal tick so the next interval starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_cnt <= '0;
        end else if (clear) begin
            sec_cnt <= '0;
        end else if (tick) begin
            if (sec_cnt == terminal) begin
                sec_cnt <= '0;
            end else begin
                sec_cnt <= sec_cnt + 1'b1;
            end
        end
    end

    assign done = tick && !clear && (sec_cnt == terminal);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm ring/snooze/lockout sequencer; ALARM_BEEP_PATTERN_EN selects 1 s on/off beeping
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick_1s,
    input  logic                            alarm_enable,
    input  logic                            alarm_match,
    input  logic                            btn_snooze,
    input  logic                            btn_stop,
    output logic                            buzzer,
    output logic                            ringing,
    output logic                            snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

    localparam int SW  = sec_width(RING_SECS, SNOOZE_SECS);
    localparam int SCW = $clog2(MAX_SNOOZE+1);

    localparam logic [SW-1:0]  RING_LAST   = SW'(RING_SECS - 1);
    localparam logic [SW-1:0]  SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
    localparam logic [SCW-1:0] SNOOZE_MAX  = SCW'(MAX_SNOOZE);

    alarm_state_t state;

    logic          counting;
    logic          snooze_ok;
    logic          timer_clear;
    logic          sec_done;
    logic [SW-1:0] terminal;

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_phase;
`endif

    assign counting  = (state == ST_RINGING) || (state == ST_SNOOZE);
    assign snooze_ok = btn_snooze && (snooze_cnt < SNOOZE_MAX);
    assign terminal  = (state == ST_RINGING) ? RING_LAST : SNOOZE_LAST;

    // Any event that leaves or restarts an interval zeroes the counter.
    assign timer_clear = !alarm_enable || !counting || btn_stop ||
                         ((state == ST_RINGING) && snooze_ok);

    alarm_sec_timer #(
        .W(SW)
    ) u_sec_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (tick_1s),
        .terminal (terminal),
        .done     (sec_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_DISARMED;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= '0;
`ifdef ALARM_BEEP_PATTERN_EN
            beep_phase <= 1'b0;
`endif
        end else if (!alarm_enable) begin
            state      <= ST_DISARMED;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= '0;
        end else begin
            case (state)
                ST_DISARMED: begin
                    state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (alarm_match) begin
                        state   <= ST_RINGING;
                        ringing <= 1'b1;
                        buzzer  <= 1'b1;
`ifdef ALARM_BEEP_PATTERN_EN
                        beep_phase <= 1'b1;
`endif
                    end
                end
                ST_RINGING: begin
                    if (btn_stop || (!snooze_ok && sec_done)) begin
                        state      <= ST_LOCKOUT;
                        ringing    <= 1'b0;
                        buzzer     <= 1'b0;
                        snooze_cnt <= '0;
                    end else if (snooze_ok) begin
                        state      <= ST_SNOOZE;
                        ringing    <= 1'b0;
                        snoozing   <= 1'b1;
                        buzzer     <= 1'b0;
                        snooze_cnt <= snooze_cnt + 1'b1;
                    end else if (tick_1s) begin
`ifdef ALARM_BEEP_PATTERN_EN
                        beep_phase <= ~beep_phase;
                        buzzer     <= ~beep_phase;
`endif
                    end
                end
                ST_SNOOZE: begin
                    if (btn_stop) begin
                        state      <= ST_LOCKOUT;
                        snoozing   <= 1'b0;
                        snooze_cnt <= '0;
                    end else if (sec_done) begin
                        // Re-ring regardless of alarm_match; the minute may have passed.
                        state    <= ST_RINGING;
                        snoozing <= 1'b0;
                        ringing  <= 1'b1;
                        buzzer   <= 1'b1;
`ifdef ALARM_BEEP_PATTERN_EN
                        beep_phase <= 1'b1;
`endif
                    end
                end
                ST_LOCKOUT: begin
                    snooze_cnt <= '0;
                    if (!alarm_match) begin
                        state <= ST_ARMED;
                    end
                end
                default: begin
                    state      <= ST_DISARMED;
                    ringing    <= 1'b0;
                    snoozing   <= 1'b0;
                    buzzer     <= 1'b0;
                    snooze_cnt <= '0;
                end
            endcase
        end
    end

endmodule
